input_pack_mem: RTL and testbench
=================================

INPUT_PACK_MEM -- requirements
Module: input_pack_mem

Interface
REQ-001 The block SHALL have parameter WORDS_PER_FRAME, default 19200, meaning the number of 128-bit words per frame (640x480 bytes / 16).
REQ-002 The block SHALL have parameter BYTES_PER_WORD, default 16, meaning the number of bytes packed into each memory word (fixed; not overridden).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: level enable; high for the whole frame.
REQ-006 The block SHALL have port input_base_offset, input, 1 bit: memory bank select, which becomes WriteAddress[15].
REQ-007 The block SHALL have port DataIn, input, 8 bits: pixel byte.
REQ-008 The block SHALL have port DataValid, input, 1 bit: DataIn is valid this cycle.
REQ-009 The block SHALL have port DataReady, output, 1 bit: the block accepts a byte this cycle.
REQ-010 The block SHALL have port WriteBus, output, 128 bits: packed word.
REQ-011 The block SHALL have port WriteAddress, output, 16 bits: {bank, word index[14:0]}.
REQ-012 The block SHALL have port WriteEnable, output, 1 bit: one-cycle memory write strobe.
REQ-013 The block SHALL have port done, output, 1 bit: the frame is completely written.

Function
REQ-014 The FSM SHALL have states IDLE, ACTIVE and DONE; IDLE->ACTIVE when start=1, ACTIVE->DONE the cycle after the last word's write strobe, any state->IDLE when start=0.
REQ-015 input_base_offset SHALL be sampled on the IDLE->ACTIVE transition and held constant for the frame.
REQ-016 DataReady SHALL be 1 only in ACTIVE, combinational on state.
REQ-017 A byte SHALL be accepted when DataValid & DataReady; a 4-bit byte counter SHALL increment per accepted byte and wrap 15->0.
REQ-018 Byte ordering SHALL be: the 1st accepted byte of a word -> WriteBus[127:120], the 2nd -> [119:112], ..., the 16th -> [7:0].
REQ-019 On acceptance of the 16th byte at edge N, WriteBus, WriteAddress={bank, word_idx} and WriteEnable=1 SHALL be registered at edge N, so they are valid in cycle N+1 only; word_idx SHALL increment at the same edge.
REQ-020 WriteEnable SHALL be high for exactly one cycle per word; WriteBus and WriteAddress SHALL hold their values until the next write.
REQ-021 Packing SHALL continue without stall during a write cycle, so back-to-back bytes sustain one word per 16 cycles.
REQ-022 When the word with word_idx = WORDS_PER_FRAME-1 is written, the FSM SHALL enter DONE, done SHALL read 1 from the following cycle, DataReady SHALL be 0, and further bytes SHALL be ignored.
REQ-023 done SHALL stay 1 while start=1 and SHALL clear the cycle after start falls.
REQ-024 If start falls mid-frame, the block SHALL go to IDLE, discard any partial word, clear the byte counter and word_idx, and issue no WriteEnable.
REQ-025 DataValid=1 while not ready SHALL be dropped silently, with no side effects.

Reset
REQ-026 On reset_n=0, the following SHALL apply asynchronously: state=IDLE, WriteBus=0, WriteAddress=0, WriteEnable=0, done=0, byte counter=0, word_idx=0, pack register=0.
REQ-027 A reset mid-frame SHALL abort the frame with no further write strobe; operation SHALL resume only on start=1 after reset release.

Structure
REQ-028 A shared package SHALL hold the state enum, FRAME_WORDS=19200, BYTES_PER_WORD=16 and ADDR_W=16; the package is shared with the output fetch path so both use identical frame geometry.
REQ-029 One sub-module, byte_packer (the shift register plus byte counter, producing word_full and the packed word), SHALL be instantiated; FSM and address logic SHALL stay in the top.

Verification
REQ-030 With reset, start=1, base=0 and bytes 0x00..0x0F on consecutive cycles, the bench SHALL see one WriteEnable with WriteBus=0x000102..0F (0x00 in [127:120]) and WriteAddress=0x0000, in the cycle after byte 0x0F.
REQ-031 With base=1 and 2 words streamed, the bench SHALL see WriteAddress 0x8000 then 0x8001 and WriteEnable pulses 16 cycles apart.
REQ-032 With WORDS_PER_FRAME overridden to 4 and 64 bytes streamed, the bench SHALL see the 4th strobe at address 0x0003, done=1 the next cycle and DataReady=0; then 5 further bytes SHALL produce no strobe; then start=0 SHALL clear done.
REQ-033 With start dropped after 7 bytes and then restarted, the bench SHALL see no strobe; the next 16 bytes SHALL write to address 0x0000 containing only the new bytes.
REQ-034 With DataValid gaps (a byte every 3rd cycle), the bench SHALL see a correct packed word and a single strobe after the 16th valid byte.
REQ-035 With reset_n pulsed low after 10 bytes, the bench SHALL see all outputs at 0 immediately and no strobe until a new start.

Source files
------------

// File: rtl/input_pack_mem_pkg.sv
// Shared frame geometry and state encoding for the input packing path.
// The output fetch path imports the same package so both sides agree on
// frame size and address layout.
package input_pack_mem_pkg;

    localparam int FRAME_WORDS    = 19200;
    localparam int BYTES_PER_WORD = 16;
    localparam int ADDR_W         = 16;
    localparam int IDX_W          = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Memory address layout: bank select on the top bit, word index below.
    function automatic logic [ADDR_W-1:0] make_addr(input logic bank,
                                                    input logic [IDX_W-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/input_pack_mem_byte_packer.sv
// Byte-to-word packer: shifts accepted bytes in MSB-first and flags the
// byte that completes a word. The completed word is presented
// combinationally so the caller can register it on the completing edge.
module byte_packer
    import input_pack_mem_pkg::*;
#(
    parameter int NBYTES = BYTES_PER_WORD
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            data_in,
    output logic                  word_full,
    output logic [NBYTES*8-1:0]   packed_word
);

    localparam int W     = NBYTES * 8;
    localparam int CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    // Only the first NBYTES-1 bytes need storage; the last byte comes
    // straight from data_in on the completing cycle.
    logic [W-9:0]     pack_r;
    logic [CNT_W-1:0] cnt_r;

    assign word_full   = accept & (cnt_r == LAST_CNT);
    assign packed_word = {pack_r, data_in};

    // Shift register and byte counter; counter wraps naturally after the last byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pack_r <= '0;
            cnt_r  <= '0;
        end else if (clear) begin
            pack_r <= '0;
            cnt_r  <= '0;
        end else if (accept) begin
            pack_r <= {pack_r[W-17:0], data_in};
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            pack_r <= pack_r;
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/input_pack_mem.sv
// Input frame packer: collects pixel bytes into wide words and writes them
// to a banked frame memory, one strobe per word, signalling done once the
// whole frame has been written.
module input_pack_mem
    import input_pack_mem_pkg::*;
#(
    parameter int WORDS_PER_FRAME = FRAME_WORDS,
    parameter int BYTES_PER_WORD  = input_pack_mem_pkg::BYTES_PER_WORD
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          input_base_offset,
    input  logic [7:0]                    DataIn,
    input  logic                          DataValid,
    output logic                          DataReady,
    output logic [BYTES_PER_WORD*8-1:0]   WriteBus,
    output logic [ADDR_W-1:0]             WriteAddress,
    output logic                          WriteEnable,
    output logic                          done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

    state_t                        state_r;
    state_t                        state_next_s;
    logic                          bank_r;
    logic [IDX_W-1:0]              idx_r;
    logic                          accept_s;
    logic                          clear_s;
    logic                          write_s;
    logic                          last_s;
    logic                          word_full_s;
    logic [BYTES_PER_WORD*8-1:0]   packed_s;

    assign DataReady = (state_r == ACTIVE);
    assign accept_s  = DataValid & DataReady;
    // Anything outside an active frame (or a dropped start) discards the partial word.
    assign clear_s   = ~start | (state_r != ACTIVE);
    // A word completed in the same cycle start falls is not written.
    assign write_s   = word_full_s & start;
    // The strobe currently on the bus carries the final word of the frame.
    assign last_s    = WriteEnable & (WriteAddress[IDX_W-1:0] == LAST_IDX);

    byte_packer #(
        .NBYTES      (BYTES_PER_WORD)
    ) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear_s),
        .accept      (accept_s),
        .data_in     (DataIn),
        .word_full   (word_full_s),
        .packed_word (packed_s)
    );

    // Next-state logic: start low always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (!start) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = ACTIVE;
                ACTIVE:  state_next_s = last_s ? DONE : ACTIVE;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bank select captured when a frame begins and held for the whole frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            bank_r <= input_base_offset;
        end else begin
            bank_r <= bank_r;
        end
    end

    // Word index advances on every written word and restarts with each frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_r <= '0;
        end else if (clear_s) begin
            idx_r <= '0;
        end else if (write_s) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Registered memory write port and done flag; bus and address hold between writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            WriteBus     <= '0;
            WriteAddress <= '0;
            WriteEnable  <= 1'b0;
            done         <= 1'b0;
        end else begin
            WriteEnable <= write_s;
            done        <= (state_next_s == DONE);
            if (write_s) begin
                WriteBus     <= packed_s;
                WriteAddress <= make_addr(bank_r, idx_r);
            end else begin
                WriteBus     <= WriteBus;
                WriteAddress <= WriteAddress;
            end
        end
    end

endmodule

// File: tb/tb_input_pack_mem.sv
// Directed bench for input_pack_mem with a 4-word frame so the end-of-frame
// behaviour is reachable quickly.
module tb_input_pack_mem;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         input_base_offset;
    logic [7:0]   DataIn;
    logic         DataValid;
    logic         DataReady;
    logic [127:0] WriteBus;
    logic [15:0]  WriteAddress;
    logic         WriteEnable;
    logic         done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cnt = 0;
    int last_we_cyc = 0;
    int prev_we_cyc = 0;
    int w0 = 0;

    input_pack_mem #(
        .WORDS_PER_FRAME   (4)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .input_base_offset (input_base_offset),
        .DataIn            (DataIn),
        .DataValid         (DataValid),
        .DataReady         (DataReady),
        .WriteBus          (WriteBus),
        .WriteAddress      (WriteAddress),
        .WriteEnable       (WriteEnable),
        .done              (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (WriteEnable === 1'b1) begin
            we_cnt++;
            prev_we_cyc = last_we_cyc;
            last_we_cyc = cyc;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        DataIn    = b;
        DataValid = 1'b1;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        input_base_offset = 1'b0;
        DataValid = 1'b0;
        DataIn = 8'h00;
        tick();
        tick();
        chk("rst_bus", WriteBus, 128'h0);
        chk("rst_addr", WriteAddress, 128'h0);
        chk("rst_we", WriteEnable, 128'h0);
        chk("rst_done", done, 128'h0);
        chk("rst_ready", DataReady, 128'h0);
        reset_n = 1'b1;
        tick();

        // First word, bank 0, bytes 00..0F back to back
        start = 1'b1;
        tick();
        chk("ready_active", DataReady, 128'h1);
        w0 = we_cnt;
        for (int i = 0; i < 15; i++) send(8'(i));
        chk("no_we_before_16th", 128'(we_cnt - w0), 128'h0);
        send(8'h0F);
        chk("w1_we", WriteEnable, 128'h1);
        chk("w1_bus", WriteBus, 128'h000102030405060708090A0B0C0D0E0F);
        chk("w1_addr", WriteAddress, 128'h0000);
        DataValid = 1'b0;
        tick();
        chk("w1_we_one_cycle", WriteEnable, 128'h0);
        chk("w1_bus_hold", WriteBus, 128'h000102030405060708090A0B0C0D0E0F);
        chk("w1_addr_hold", WriteAddress, 128'h0000);
        chk("w1_count", 128'(we_cnt - w0), 128'h1);
        start = 1'b0;
        tick();

        // Bank 1, two words streamed back to back
        input_base_offset = 1'b1;
        start = 1'b1;
        tick();
        input_base_offset = 1'b0;
        w0 = we_cnt;
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
        chk("b1_addr0", WriteAddress, 128'h8000);
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        chk("b1_addr1", WriteAddress, 128'h8001);
        chk("b1_bus1", WriteBus, 128'h303132333435363738393A3B3C3D3E3F);
        chk("b1_spacing", 128'(last_we_cyc - prev_we_cyc), 128'd16);
        chk("b1_count", 128'(we_cnt - w0), 128'h2);
        DataValid = 1'b0;
        start = 1'b0;
        tick();

        // Full 4-word frame, then done behaviour
        start = 1'b1;
        tick();
        w0 = we_cnt;
        for (int i = 0; i < 64; i++) send(8'(i));
        chk("fr_last_we", WriteEnable, 128'h1);
        chk("fr_last_addr", WriteAddress, 128'h0003);
        chk("fr_last_bus", WriteBus, 128'h303132333435363738393A3B3C3D3E3F);
        chk("fr_done_not_yet", done, 128'h0);
        chk("fr_count", 128'(we_cnt - w0), 128'h4);
        DataValid = 1'b0;
        tick();
        chk("fr_done", done, 128'h1);
        chk("fr_ready_low", DataReady, 128'h0);
        w0 = we_cnt;
        for (int i = 0; i < 5; i++) send(8'hEE);
        chk("fr_ignored", 128'(we_cnt - w0), 128'h0);
        chk("fr_done_held", done, 128'h1);
        chk("fr_bus_unchanged", WriteBus, 128'h303132333435363738393A3B3C3D3E3F);
        DataValid = 1'b0;
        start = 1'b0;
        tick();
        chk("fr_done_clear", done, 128'h0);

        // Abort after 7 bytes, then a fresh frame
        start = 1'b1;
        tick();
        w0 = we_cnt;
        for (int i = 0; i < 7; i++) send(8'hA0 + 8'(i));
        DataValid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("ab_no_we", 128'(we_cnt - w0), 128'h0);
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
        chk("ab_bus", WriteBus, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        chk("ab_addr", WriteAddress, 128'h0000);
        chk("ab_count", 128'(we_cnt - w0), 128'h1);
        DataValid = 1'b0;

        // Bytes offered while idle are dropped; then gappy input
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send(8'hFF);
        chk("idle_ready_low", DataReady, 128'h0);
        DataValid = 1'b0;
        start = 1'b1;
        tick();
        w0 = we_cnt;
        for (int i = 0; i < 15; i++) begin
            send(8'h50 + 8'(i));
            DataValid = 1'b0;
            tick();
            tick();
        end
        chk("gap_no_we_early", 128'(we_cnt - w0), 128'h0);
        send(8'h5F);
        chk("gap_we", WriteEnable, 128'h1);
        chk("gap_bus", WriteBus, 128'h505152535455565758595A5B5C5D5E5F);
        chk("gap_addr", WriteAddress, 128'h0000);
        DataValid = 1'b0;
        tick();
        tick();
        chk("gap_count", 128'(we_cnt - w0), 128'h1);

        // Asynchronous reset after 10 bytes
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send(8'h60 + 8'(i));
        DataValid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("ar_bus", WriteBus, 128'h0);
        chk("ar_addr", WriteAddress, 128'h0);
        chk("ar_we", WriteEnable, 128'h0);
        chk("ar_done", done, 128'h0);
        chk("ar_ready", DataReady, 128'h0);
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        w0 = we_cnt;
        for (int i = 0; i < 5; i++) send(8'h99);
        chk("ar_no_we", 128'(we_cnt - w0), 128'h0);
        chk("ar_idle_ready", DataReady, 128'h0);
        DataValid = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(8'h70 + 8'(i));
        chk("ar_new_bus", WriteBus, 128'h707172737475767778797A7B7C7D7E7F);
        chk("ar_new_addr", WriteAddress, 128'h0000);
        chk("ar_new_count", 128'(we_cnt - w0), 128'h1);
        DataValid = 1'b0;
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
